// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: class/immediate codes, opcode
// values and the decoded-field record carried through the output queue.
package decode_pkg;

  typedef enum logic [3:0] {
    IT_UNKNOWN  = 4'b0000,
    IT_LOAD     = 4'b0001,
    IT_STORE    = 4'b0010,
    IT_OP       = 4'b0011,
    IT_OP_IMM   = 4'b0100,
    IT_BRANCH   = 4'b0101,
    IT_JAL      = 4'b0110,
    IT_JALR     = 4'b0111,
    IT_LUI      = 4'b1000,
    IT_AUIPC    = 4'b1001,
    IT_SYSTEM   = 4'b1010,
    IT_MISC_MEM = 4'b1011
  } inst_type_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_R    = 3'b010,
    IMM_B    = 3'b011,
    IMM_J    = 3'b100,
    IMM_U    = 3'b101,
    IMM_NONE = 3'b111
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [6:0] opcode;
    inst_type_e inst_type;
    imm_type_e  imm_type;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I field extraction: raw instruction to decoded record
// plus a 32-bit sign-extended immediate. The illegal-encoding check is built
// only when DECODE_ILLEGAL_CHECK_EN is defined; otherwise illegal stays 0.
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec,
  output logic [31:0] imm
);

  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

`ifdef DECODE_ILLEGAL_CHECK_EN
  function automatic logic illegal_chk(input logic [31:0] i);
    logic [2:0] c3;
    logic [6:0] c7;
    logic       bad;
    c3  = i[14:12];
    c7  = i[31:25];
    bad = 1'b0;
    case (i[6:0])
      OPC_OP:     bad = !((c7 == 7'h00) ||
                          ((c7 == 7'h20) && ((c3 == 3'b000) || (c3 == 3'b101))));
      OPC_OP_IMM: if ((c3 == 3'b001) || (c3 == 3'b101))
                    bad = !((c7 == 7'h00) || ((c7 == 7'h20) && (c3 == 3'b101)));
      OPC_LOAD:   bad = (c3 == 3'b011) || (c3 == 3'b110) || (c3 == 3'b111);
      OPC_STORE:  bad = (c3 > 3'b010);
      OPC_BRANCH: bad = (c3 == 3'b010) || (c3 == 3'b011);
      OPC_JALR:   bad = (c3 != 3'b000);
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_MISC_MEM: bad = 1'b0;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction
`endif

  // Format-driven field selection; fields absent from a format stay zero.
  always_comb begin
    dec           = '0;
    dec.inst_type = IT_UNKNOWN;
    dec.imm_type  = IMM_NONE;
    imm           = '0;
    case (instr[6:0])
      OPC_OP: begin
        dec.inst_type = IT_OP;
        dec.imm_type  = IMM_R;
        dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
        dec.func3 = f3; dec.func7 = f7;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        case (instr[6:0])
          OPC_OP_IMM: dec.inst_type = IT_OP_IMM;
          OPC_LOAD:   dec.inst_type = IT_LOAD;
          OPC_JALR:   dec.inst_type = IT_JALR;
          OPC_SYSTEM: dec.inst_type = IT_SYSTEM;
          default:    dec.inst_type = IT_MISC_MEM;
        endcase
        dec.imm_type = IMM_I;
        dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.func3 = f3;
        if (instr[6:0] == OPC_OP_IMM) dec.func7 = f7;
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        dec.inst_type = IT_STORE;
        dec.imm_type  = IMM_S;
        dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.func3 = f3;
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.inst_type = IT_BRANCH;
        dec.imm_type  = IMM_B;
        dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.func3 = f3;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec.inst_type = IT_JAL;
        dec.imm_type  = IMM_J;
        dec.rd = instr[11:7];
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.inst_type = (instr[6:0] == OPC_LUI) ? IT_LUI : IT_AUIPC;
        dec.imm_type  = IMM_U;
        dec.rd = instr[11:7];
        imm = {instr[31:12], 12'b0};
      end
      default: ;
    endcase
    if (dec.inst_type != IT_UNKNOWN) dec.opcode = instr[6:0];
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = illegal_chk(instr);
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes the offered instruction and writes
// the result into a DEPTH-entry queue; outputs come straight from the head
// entry. Optional illegal-encoding flag: DECODE_ILLEGAL_CHECK_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               out_opcode,
  output logic [3:0]               out_inst_type,
  output logic [2:0]               out_imm_type,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_func3,
  output logic [6:0]               out_func7,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    decoded_t        dec;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  decoded_t        dec;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  entry_t          head;
  logic            push, pop;

  decode_fields u_fields (
    .instr (in_instr),
    .dec   (dec),
    .imm   (imm32)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Widen the 32-bit immediate by replicating its sign bit.
  always_comb begin
    imm_ext        = {XLEN{imm32[31]}};
    imm_ext[31:0]  = imm32;
  end

  assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Queue next-state: write at tail, advance head on pop, flush clears.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{dec: dec, pc: in_pc, imm: imm_ext};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state; reset clears storage so every output reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_pc        = head.pc;
  assign out_imm       = head.imm;
  assign out_opcode    = head.dec.opcode;
  assign out_inst_type = head.dec.inst_type;
  assign out_imm_type  = head.dec.imm_type;
  assign out_rd        = head.dec.rd;
  assign out_rs1       = head.dec.rs1;
  assign out_rs2       = head.dec.rs2;
  assign out_func3     = head.dec.func3;
  assign out_func7     = head.dec.func7;
  assign out_illegal   = head.dec.illegal;
  assign count         = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted instructions push their
// hand-decoded expectation; a monitor pops and compares on every transfer.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int NV    = 15;

  logic            clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic            in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            in_ready, out_valid, out_illegal;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [6:0]      out_opcode, out_func7;
  logic [3:0]      out_inst_type;
  logic [2:0]      out_imm_type, out_func3;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [1:0]      count;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_inst_type(out_inst_type), .out_imm_type(out_imm_type),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [3:0]  ty;
    logic [2:0]  it;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef logic [103:0] exp_t;

  vec_t vec [NV];
  exp_t sb [$];
  int   checks = 0, passes = 0, cur_idx = 0, cyc = 0;

  wire exp_t act = {out_pc, out_opcode, out_inst_type, out_imm_type, out_rd, out_rs1,
                    out_rs2, out_func3, out_func7, out_imm, out_illegal};

  function automatic exp_t exp_of(int i);
    logic ill;
`ifdef DECODE_ILLEGAL_CHECK_EN
    ill = vec[i].ill;
`else
    ill = 1'b0;
`endif
    return {32'(32'h1000 + 4 * i), vec[i].op, vec[i].ty, vec[i].it, vec[i].rd, vec[i].rs1,
            vec[i].rs2, vec[i].f3, vec[i].f7, vec[i].imm, ill};
  endfunction

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation side: record every accepted instruction, drop on flush/reset.
  always @(negedge clk) begin
    if (!rst || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(exp_of(cur_idx));
  end

  // Monitor: compare the head against the oldest expectation on each pop.
  always @(negedge clk) begin
    exp_t e;
    if (rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL pop_unexpected: got %0h expected no entry", act);
      end else begin
        e = sb.pop_front();
        check("entry", act, e);
      end
    end
  end

  task automatic send(input int i);
    bit ok = 0;
    in_valid = 1'b1;
    in_instr = vec[i].instr;
    in_pc    = 32'(32'h1000 + 4 * i);
    cur_idx  = i;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: got no accept expected accept of vector %0d", i);
    end
  endtask

  task automatic wait_empty();
    out_ready = 1'b1;
    for (int n = 0; n < 50 && count != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain_count", count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    vec[0]  = '{32'h00500093, 7'h13, 4'd4,  3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 1'b0};
    vec[1]  = '{32'hFE000EE3, 7'h63, 4'd5,  3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0};
    vec[2]  = '{32'h002081B3, 7'h33, 4'd3,  3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 1'b0};
    vec[3]  = '{32'h40001033, 7'h33, 4'd3,  3'd2, 5'd0, 5'd0, 5'd0, 3'd1, 7'h20, 32'h00000000, 1'b1};
    vec[4]  = '{32'h00000000, 7'h00, 4'd0,  3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1};
    vec[5]  = '{32'h123452B7, 7'h37, 4'd8,  3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0};
    vec[6]  = '{32'h008000EF, 7'h6F, 4'd6,  3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1'b0};
    vec[7]  = '{32'hFE20AC23, 7'h23, 4'd2,  3'd1, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFFFF8, 1'b0};
    vec[8]  = '{32'h00003083, 7'h03, 4'd1,  3'd0, 5'd1, 5'd0, 5'd0, 3'd3, 7'h00, 32'h00000000, 1'b1};
    vec[9]  = '{32'h00008067, 7'h67, 4'd7,  3'd0, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0};
    vec[10] = '{32'h00000073, 7'h73, 4'd10, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0};
    vec[11] = '{32'h0FF0000F, 7'h0F, 4'd11, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000000FF, 1'b0};
    vec[12] = '{32'hFFFFF117, 7'h17, 4'd9,  3'd5, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b0};
    vec[13] = '{32'h4030D093, 7'h13, 4'd4,  3'd0, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h00000403, 1'b0};
    vec[14] = '{32'h40309093, 7'h13, 4'd4,  3'd0, 5'd1, 5'd1, 5'd0, 3'd1, 7'h20, 32'h00000403, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_fields", act, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single-cycle latency into an empty queue
    send(0);
    check("latency_valid", out_valid, 1);
    check("latency_count", count, 1);
    wait_empty();
    out_ready = 1'b0;
    send(1);
    wait_empty();
    out_ready = 1'b0;

    // Fill with consumer stalled, then release and keep offering
    send(2);
    send(3);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 2);
    out_ready = 1'b1;
    send(4);
    send(5);
    wait_empty();
    out_ready = 1'b0;

    // Pop-only then simultaneous push and pop
    send(6);
    send(7);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("pop_count", count, 1);
    check("ready_after_pop", in_ready, 1);
    in_valid = 1'b1; in_instr = vec[8].instr; in_pc = 32'h1000 + 32'd32; cur_idx = 8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pushpop_count", count, 1);
    wait_empty();
    out_ready = 1'b0;

    // Flush with a full queue and an offered instruction
    send(9);
    send(10);
    in_valid = 1'b1; in_instr = vec[11].instr; in_pc = 32'h1000 + 32'd44; cur_idx = 11;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    @(posedge clk); #1;
    check("flush_dropped", out_valid, 0);

    // Asynchronous reset mid-stream
    send(12);
    #3 rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_count", count, 0);
    check("midrst_fields", act, 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Full-rate stream of every vector
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < NV; i++) send(i);
    check("throughput_cycles", cyc - t0, NV);
    wait_empty();
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
